// File: rtl/i2s_pkg.sv
// Shared I2S framing constants. The receive side imports the same package so
// both directions number frame bits and slots identically.
package i2s_pkg;

    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_BCNT_W     = 6;

    // Philips framing: slot bit 0 is the one-bit delay after WS changes, and
    // the MSB of the channel word follows immediately after it.
    localparam logic [4:0] I2S_DELAY_SLOT      = 5'd0;
    localparam logic [4:0] I2S_FIRST_DATA_SLOT = 5'd1;

    typedef enum logic {
        I2S_CH_LEFT  = 1'b0,
        I2S_CH_RIGHT = 1'b1
    } i2s_chan_e;

    // The top bit of the frame bit counter doubles as word select.
    function automatic i2s_chan_e i2s_chan(input logic [I2S_BCNT_W-1:0] bc);
        return i2s_chan_e'(bc[I2S_BCNT_W-1]);
    endfunction

endpackage

// File: rtl/i2s_dac_tx_fifo.sv
// Synchronous FIFO for sample pairs. Full/empty come from an occupancy count,
// so the pointers simply wrap modulo the power-of-two depth.
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S (Philips) stereo transmitter: FIFO-buffered sample pairs, CLK-derived
// SCK/WS, 64-bit frames MSB first. Define I2S_DAC_HOLD_EN to repeat the last
// pair on underrun instead of sending silence.
module i2s_dac_tx
    import i2s_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int FIFO_AW = 3,
    parameter int SCK_DIV = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_left,
    input  logic signed [WIDTH-1:0] in_right,
    output logic                    sck,
    output logic                    ws,
    output logic                    sd,
    output logic                    underrun,
    output logic [FIFO_AW:0]        level
);

    localparam int                    DIV_W     = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(SCK_DIV - 1);
    localparam logic [I2S_BCNT_W-1:0] BCNT_LAST = I2S_BCNT_W'(I2S_FRAME_BITS - 1);
    localparam int                    SLOT_W    = $clog2(I2S_SLOT_BITS);
    localparam logic [SLOT_W:0]       WIDTH_S   = (SLOT_W + 1)'(WIDTH);

    logic [DIV_W-1:0]         div_cnt;
    logic [I2S_BCNT_W-1:0]    bit_cnt;
    logic [I2S_BCNT_W-1:0]    bit_nxt;
    logic signed [WIDTH-1:0]  left_hold;
    logic signed [WIDTH-1:0]  right_hold;
    logic                     div_tc;
    logic                     fall;
    logic                     frame_load;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [2*WIDTH-1:0]       fifo_rdata;

    // Serial bit for a frame position; zero in the delay slot and past the word.
    function automatic logic slot_bit(input logic [I2S_BCNT_W-1:0] bc,
                                      input logic [WIDTH-1:0]      l,
                                      input logic [WIDTH-1:0]      r);
        logic [SLOT_W-1:0] s;
        logic [WIDTH-1:0]  ch;
        logic [WIDTH-1:0]  aligned;
        s       = bc[SLOT_W-1:0];
        ch      = (i2s_chan(bc) == I2S_CH_RIGHT) ? r : l;
        aligned = ch << (s - I2S_FIRST_DATA_SLOT);
        if (s == I2S_DELAY_SLOT || {1'b0, s} > WIDTH_S) begin
            return 1'b0;
        end
        return aligned[WIDTH-1];
    endfunction

    assign in_ready   = !fifo_full;
    assign fifo_push  = in_valid && !fifo_full;
    assign div_tc     = (div_cnt == DIV_LAST);
    assign fall       = div_tc && sck;
    assign bit_nxt    = bit_cnt + 1'b1;
    assign frame_load = fall && (bit_cnt == BCNT_LAST);
    assign fifo_pop   = frame_load && !fifo_empty;

    sync_fifo #(
        .DATA_W (2 * WIDTH),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RST),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  ({in_left, in_right}),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (div_tc) begin
            div_cnt <= '0;
            sck     <= !sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Everything below advances on SCK falling so the DAC samples on rises.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt    <= BCNT_LAST;
            ws         <= 1'b1;
            sd         <= 1'b0;
            underrun   <= 1'b0;
            left_hold  <= '0;
            right_hold <= '0;
        end else begin
            underrun <= 1'b0;
            if (fall) begin
                bit_cnt <= bit_nxt;
                ws      <= bit_nxt[I2S_BCNT_W-1];
                sd      <= slot_bit(bit_nxt, left_hold, right_hold);
            end
            if (frame_load) begin
                underrun <= fifo_empty;
                if (!fifo_empty) begin
                    left_hold  <= fifo_rdata[2*WIDTH-1:WIDTH];
                    right_hold <= fifo_rdata[WIDTH-1:0];
                end
`ifndef I2S_DAC_HOLD_EN
                else begin
                    left_hold  <= '0;
                    right_hold <= '0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: a pair queue and frame timing model run in
// lock-step with the DUT and every observable output is compared each cycle.
module tb_i2s_dac_tx;

    localparam int WIDTH      = 16;
    localparam int FIFO_AW    = 3;
    localparam int SCK_DIV    = 4;
    localparam int DEPTH      = 1 << FIFO_AW;
    localparam int BIT_CLKS   = 2 * SCK_DIV;
    localparam int FRAME_CLKS = 64 * BIT_CLKS;
    localparam int FIRST      = BIT_CLKS;

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               in_valid = 1'b0;
    logic [WIDTH-1:0]   in_left = '0;
    logic [WIDTH-1:0]   in_right = '0;
    logic               in_ready;
    logic               sck;
    logic               ws;
    logic               sd;
    logic               underrun;
    logic [FIFO_AW:0]   level;

    always #5 CLK = ~CLK;

    i2s_dac_tx #(
        .WIDTH   (WIDTH),
        .FIFO_AW (FIFO_AW),
        .SCK_DIV (SCK_DIV)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_left  (in_left),
        .in_right (in_right),
        .sck      (sck),
        .ws       (ws),
        .sd       (sd),
        .underrun (underrun),
        .level    (level)
    );

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] mq[$];
    logic [31:0] cur = '0;
    logic [31:0] last = '0;
    logic        ur_exp = 1'b0;
    logic [63:0] cap = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        int o;
        int b;
        int ph;
        chk("level", 64'(level), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        chk("sck", 64'(sck), 64'((cyc / SCK_DIV) % 2));
        chk("underrun", 64'(underrun), 64'(ur_exp));
        if (cyc < FIRST) begin
            chk("ws_idle", 64'(ws), 64'(1));
            chk("sd_idle", 64'(sd), 64'(0));
        end else begin
            o  = cyc - FIRST;
            b  = (o / BIT_CLKS) % 64;
            ph = o % BIT_CLKS;
            chk("ws", 64'(ws), 64'(b >= 32));
            if (ph == SCK_DIV) begin
                cap[63-b] = sd;
                if (b == 63) begin
                    chk("frame", cap, {1'b0, cur[31:16], 15'b0, 1'b0, cur[15:0], 15'b0});
                end
            end
        end
    endtask

    // One CLK: update the reference at the edge, then compare at the falling edge.
    task automatic tick();
        logic        acc;
        logic [31:0] pr;
        @(posedge CLK);
        if (RST) begin
            cyc = 0;
            mq.delete();
            cur = '0;
            last = '0;
            ur_exp = 1'b0;
        end else begin
            cyc++;
            acc = in_valid && (mq.size() < DEPTH);
            pr = {in_left, in_right};
            ur_exp = 1'b0;
            if (cyc >= FIRST && (cyc - FIRST) % FRAME_CLKS == 0) begin
                if (mq.size() > 0) begin
                    cur = mq.pop_front();
                    last = cur;
                end else begin
                    ur_exp = 1'b1;
`ifdef I2S_DAC_HOLD_EN
                    cur = last;
`else
                    cur = '0;
`endif
                end
            end
            if (acc) mq.push_back(pr);
        end
        @(negedge CLK);
        monitor();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        in_valid = 1'b1;
        in_left = l;
        in_right = r;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic run_to(input int c);
        for (int i = 0; i < 20000 && cyc < c; i++) tick();
        chk("run_to_reached", 64'(cyc >= c), 64'(1));
    endtask

    initial begin
        // Reset state and idle frames with nothing queued
        do_reset();
        chk("rst_level", 64'(level), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_ws", 64'(ws), 64'(1));
        run_to(FIRST + 2 * FRAME_CLKS);

        // Single pair queued before the first frame
        do_reset();
        push(16'hA5C3, 16'h8001);
        run_to(FIRST + FRAME_CLKS + 8);

        // Fill the FIFO, then hold a ninth pair until a frame load frees space
        do_reset();
        run_to(10);
        for (int k = 0; k < 8; k++) begin
            push(16'(16'h1000 + k * 16'h0111), 16'(~(16'h1000 + k * 16'h0111)));
        end
        chk("full_in_ready", 64'(in_ready), 64'(0));
        chk("full_level", 64'(level), 64'(8));
        in_valid = 1'b1;
        in_left = 16'h7FFF;
        in_right = 16'h8000;
        run_to(FIRST + FRAME_CLKS);
        chk("pop_in_ready", 64'(in_ready), 64'(1));
        chk("pop_level", 64'(level), 64'(7));
        tick();
        in_valid = 1'b0;
        chk("refill_level", 64'(level), 64'(8));
        run_to(FIRST + 3 * FRAME_CLKS + 8);

        // Push on the very edge of a frame load with the FIFO empty
        do_reset();
        run_to(FIRST - 1);
        push(16'h7E01, 16'h0180);
        chk("edge_push_underrun", 64'(underrun), 64'(1));
        chk("edge_push_level", 64'(level), 64'(1));
        run_to(FIRST + 2 * FRAME_CLKS);

        // Reset in the middle of the right slot with three pairs still queued
        do_reset();
        push(16'h0F0F, 16'hFFFF);
        push(16'h1111, 16'h2222);
        push(16'h3333, 16'h4444);
        push(16'h5555, 16'h6666);
        run_to(FIRST + 40 * BIT_CLKS + SCK_DIV);
        chk("pre_rst_sd", 64'(sd), 64'(1));
        chk("pre_rst_level", 64'(level), 64'(3));
        #2 RST = 1'b1;
        #1;
        chk("async_rst_sck", 64'(sck), 64'(0));
        chk("async_rst_ws", 64'(ws), 64'(1));
        chk("async_rst_sd", 64'(sd), 64'(0));
        chk("async_rst_level", 64'(level), 64'(0));
        chk("async_rst_in_ready", 64'(in_ready), 64'(1));
        tick();
        tick();
        RST = 1'b0;
        run_to(FIRST);
        chk("post_rst_underrun", 64'(underrun), 64'(1));
        run_to(FIRST + FRAME_CLKS);

        // One pair then starvation: repeated or silent frames depending on build
        do_reset();
        push(16'h1234, 16'h5678);
        run_to(FIRST + 3 * FRAME_CLKS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
